// File: rtl/huff_bit_feeder.sv
// Bit feeder for a Huffman decoder: buffers stream bytes in a holding register
// plus a one-entry skid register and emits MSB-first chunks of up to CHUNK_MAX bits.
module huff_bit_feeder #(
    parameter int CHUNK_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic [3:0] s_nbits,
    output logic       s_ready,
    output logic [3:0] out_bits,
    output logic [2:0] out_len,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       done,
    output logic [1:0] dbg_state
);

    // Handshakes: a beat transfers on the rising edge where valid && ready are both
    // high; the source holds payload stable while valid && !ready and never retracts it.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_END  = 2'd2
    } state_t;

    localparam logic [3:0] CMAX = 4'(CHUNK_MAX);

    state_t     state;
    logic [7:0] h_data, sk_data;
    logic [3:0] h_rem, sk_rem;
    logic       h_last, sk_last;
    logic       done_q;

    logic       h_occ, sk_occ, xfer, accept, move, to_h;
    logic [3:0] n, rem_after, in_rem, h_rem_nxt;
    logic [7:0] shifted, data_after;

    always_comb begin
        h_occ      = (h_rem != 4'd0);
        sk_occ     = (sk_rem != 4'd0);
        n          = (h_rem < CMAX) ? h_rem : CMAX;
        shifted    = h_data >> (4'd8 - n);
        xfer       = h_occ && out_ready;
        rem_after  = xfer ? (h_rem - n) : h_rem;
        data_after = xfer ? 8'(h_data << n) : h_data;
        // S only refills H once H has fully drained on this edge
        move       = (rem_after == 4'd0) && sk_occ;
        accept     = s_valid && !sk_occ;
        to_h       = accept && (rem_after == 4'd0);
        in_rem     = (s_last && s_nbits != 4'd0 && s_nbits <= 4'd8) ? s_nbits : 4'd8;
        if (move)      h_rem_nxt = sk_rem;
        else if (to_h) h_rem_nxt = in_rem;
        else           h_rem_nxt = rem_after;
    end

    assign s_ready   = !sk_occ;
    assign out_valid = h_occ;
    assign out_len   = h_occ ? n[2:0] : 3'd0;
    assign out_bits  = h_occ ? shifted[3:0] : 4'd0;
    assign out_last  = h_occ && h_last && (h_rem == n);
    assign done      = done_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            h_data  <= 8'd0;
            h_rem   <= 4'd0;
            h_last  <= 1'b0;
            sk_data <= 8'd0;
            sk_rem  <= 4'd0;
            sk_last <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            h_rem <= h_rem_nxt;
            if (move) begin
                h_data  <= sk_data;
                h_last  <= sk_last;
                sk_rem  <= 4'd0;
            end else if (to_h) begin
                h_data  <= s_data;
                h_last  <= s_last;
            end else begin
                h_data  <= data_after;
            end

            if (accept && !to_h) begin
                sk_data <= s_data;
                sk_rem  <= in_rem;
                sk_last <= s_last;
            end

            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (h_rem_nxt != 4'd0) state <= ST_EMIT;
                ST_EMIT: begin
                    if (xfer && out_last) begin
                        state  <= ST_END;
                        done_q <= 1'b1;
                    end else if (h_rem_nxt == 4'd0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_END:  state <= (h_rem_nxt != 4'd0) ? ST_EMIT : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_bit_feeder.sv
// Bench for huff_bit_feeder: three instances (CHUNK_MAX 4, 3, 1) with a chunk
// scoreboard per instance, directed scenarios and a randomised tail.
module tb_huff_bit_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_last;
    logic [3:0] s_nbits;
    logic       out_ready;
    logic       s_valid_v   [3];
    logic       s_ready_v   [3];
    logic [3:0] out_bits_v  [3];
    logic [2:0] out_len_v   [3];
    logic       out_valid_v [3];
    logic       out_last_v  [3];
    logic       done_v      [3];
    logic [1:0] dbg_state_v [3];

    int  tests = 0;
    int  fails = 0;
    bit  rand_ready = 0;
    bit  done_due [3];
    logic [7:0] exp_q0[$], exp_q1[$], exp_q2[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        huff_bit_feeder #(.CHUNK_MAX(g == 0 ? 4 : (g == 1 ? 3 : 1))) u_dut (
            .clk(clk), .reset(rst_n),
            .s_data(s_data), .s_valid(s_valid_v[g]), .s_last(s_last), .s_nbits(s_nbits),
            .s_ready(s_ready_v[g]),
            .out_bits(out_bits_v[g]), .out_len(out_len_v[g]), .out_valid(out_valid_v[g]),
            .out_ready(out_ready), .out_last(out_last_v[g]), .done(done_v[g]),
            .dbg_state(dbg_state_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cmax(input int w);
        return (w == 0) ? 4 : ((w == 1) ? 3 : 1);
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic qpush(input int w, input logic [7:0] v);
        case (w)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic qpop(input int w, output logic [7:0] v, output bit ok);
        ok = (qsize(w) != 0);
        v  = 8'd0;
        if (ok) begin
            case (w)
                0:       v = exp_q0.pop_front();
                1:       v = exp_q1.pop_front();
                default: v = exp_q2.pop_front();
            endcase
        end
    endtask

    task automatic qflush();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    endtask

    // Expected chunk entry: {last, len[2:0], bits[3:0]}
    task automatic push_chunks(input int w, input logic [7:0] d, input bit last, input logic [3:0] nb);
        int rem, n;
        logic [7:0] data, b;
        rem  = (last && nb != 0 && nb <= 8) ? int'(nb) : 8;
        data = d;
        while (rem > 0) begin
            n    = (rem < cmax(w)) ? rem : cmax(w);
            b    = 8'd0;
            for (int i = 0; i < n; i++) b = {b[6:0], data[7 - i]};
            data = data << n;
            rem  = rem - n;
            qpush(w, {(last && rem == 0), 3'(n), b[3:0]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input int w, input logic [7:0] d, input bit last, input logic [3:0] nb);
        bit taken = 0;
        s_data       = d;
        s_last       = last;
        s_nbits      = nb;
        s_valid_v[w] = 1'b1;
        for (int t = 0; t < 60 && !taken; t++) begin
            @(negedge clk);
            if (s_ready_v[w]) begin
                push_chunks(w, d, last, nb);
                taken = 1;
                step();
            end
        end
        if (!taken) check($sformatf("accept_timeout%0d", w), 0, 1);
        s_valid_v[w] = 1'b0;
    endtask

    task automatic wait_done(input int w);
        bit seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = done_v[w];
        end
        check($sformatf("done_seen%0d", w), 32'(seen), 1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge clk);
            idle = !out_valid_v[0] && !out_valid_v[1] && !out_valid_v[2];
        end
        check("drain_timeout", 32'(idle), 1);
    endtask

    task automatic mon(input int w);
        logic [7:0] e;
        bit ok;
        if (!rst_n) begin
            done_due[w] = 0;
            return;
        end
        check($sformatf("done%0d", w), 32'(done_v[w]), 32'(done_due[w]));
        done_due[w] = out_valid_v[w] && out_ready && out_last_v[w];
        if (out_valid_v[w] && out_ready) begin
            qpop(w, e, ok);
            if (!ok) check($sformatf("chunk_unexpected%0d", w), {out_last_v[w], out_len_v[w], out_bits_v[w]}, 32'h1ff);
            else     check($sformatf("chunk%0d", w), {out_last_v[w], out_len_v[w], out_bits_v[w]}, e);
        end
    endtask

    always @(negedge clk) for (int w = 0; w < 3; w++) mon(w);

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        s_data    = 8'd0;
        s_last    = 1'b0;
        s_nbits   = 4'd0;
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) s_valid_v[w] = 1'b0;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_v[0]), 0);
        check("rst_out_len",   32'(out_len_v[0]), 0);
        check("rst_out_bits",  32'(out_bits_v[0]), 0);
        check("rst_out_last",  32'(out_last_v[0]), 0);
        check("rst_done",      32'(done_v[0]), 0);
        check("rst_s_ready",   32'(s_ready_v[0]), 1);
        check("rst_state",     32'(dbg_state_v[0]), 0);
        step();
        rst_n = 1'b1;

        // Two back-to-back bytes: four chunks with no bubble
        send_byte(0, 8'hA5, 0, 0);
        send_byte(0, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_bubble", 32'(out_valid_v[0]), 1);
        end
        @(negedge clk);
        check("drained", 32'(out_valid_v[0]), 0);

        // Short last byte and the done pulse
        step();
        send_byte(0, 8'hB0, 1, 3);
        wait_done(0);
        @(negedge clk);
        check("done_one_cycle", 32'(done_v[0]), 0);

        // Back-pressure: chunk held, skid fills, third byte refused
        step();
        out_ready = 1'b0;
        send_byte(0, 8'hA5, 0, 0);
        repeat (5) begin
            @(negedge clk);
            check("hold_bits",  32'(out_bits_v[0]), 32'hA);
            check("hold_len",   32'(out_len_v[0]), 4);
            check("hold_valid", 32'(out_valid_v[0]), 1);
        end
        step();
        send_byte(0, 8'h3C, 0, 0);
        s_data = 8'h77;
        s_valid_v[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("skid_full", 32'(s_ready_v[0]), 0);
        end
        step();
        s_valid_v[0] = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("q_drained0", 32'(qsize(0)), 0);

        // CHUNK_MAX=3, full last byte
        step();
        send_byte(1, 8'hFF, 1, 0);
        wait_done(1);

        // CHUNK_MAX=1, five-bit last byte
        step();
        send_byte(2, 8'hA5, 1, 5);
        wait_done(2);

        // Reset mid-byte discards remaining bits
        step();
        send_byte(0, 8'h5A, 0, 0);
        step();
        rst_n = 1'b0;
        qflush();
        #1;
        check("midrst_valid",   32'(out_valid_v[0]), 0);
        check("midrst_s_ready", 32'(s_ready_v[0]), 1);
        step();
        step();
        rst_n = 1'b1;
        send_byte(0, 8'h12, 1, 0);
        wait_done(0);

        // Random bytes across all instances with random back-pressure
        step();
        rand_ready = 1;
        for (int i = 0; i < 30; i++) begin
            send_byte($urandom_range(0, 2), 8'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 8)));
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) check($sformatf("q_empty%0d", w), 32'(qsize(w)), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
